// File: rtl/controlword_pkg.sv
// Shared definitions for the control-word sequencer: control-word field
// positions, register widths, PC function encodings and status bit indices.
package controlword_pkg;

    localparam int CW_WIDTH     = 33;
    localparam int STATE_WIDTH  = 2;
    localparam int STATUS_WIDTH = 5;

    // Bit positions of the fields the sequencer consumes; everything above
    // CW_RF_WRITE belongs to the datapath and is passed through untouched.
    localparam int CW_RF_WRITE      = 9;
    localparam int CW_RAM_DB_EN     = 8;
    localparam int CW_RAM_WRITE     = 7;
    localparam int CW_PC_DB_EN      = 6;
    localparam int CW_PC_FUNC_HI    = 5;
    localparam int CW_PC_FUNC_LO    = 4;
    localparam int CW_PC_IN_SEL     = 3;
    localparam int CW_STATUS_LOAD   = 2;
    localparam int CW_NEXT_STATE_HI = 1;
    localparam int CW_NEXT_STATE_LO = 0;

    localparam int STATUS_Z = 0;

    typedef enum logic [1:0] {
        PC_HOLD = 2'b00,
        PC_INC  = 2'b01,
        PC_LOAD = 2'b10,
        PC_REL  = 2'b11
    } pc_func_t;

    // Sequential successor / link address.
    function automatic logic [63:0] pc_plus4(input logic [63:0] p);
        return p + 64'd4;
    endfunction

endpackage

// File: rtl/controlword_sequencer_program_counter.sv
// Program counter register and next-PC selection (hold, +4, absolute
// load, word-scaled relative). Updates only while enable is high.
module program_counter
    import controlword_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  pc_func_t    func,
    input  logic [63:0] operand,
    output logic [63:0] pc,
    output logic [63:0] pc_seq
);

    logic [63:0] pc_reg;
    logic [63:0] pc_next;

    assign pc     = pc_reg;
    assign pc_seq = pc_plus4(pc_reg);

    // Next-PC mux; all arithmetic wraps modulo 2^64.
    always_comb begin
        pc_next = pc_reg;
        case (func)
            PC_HOLD: pc_next = pc_reg;
            PC_INC:  pc_next = pc_plus4(pc_reg);
            PC_LOAD: pc_next = operand;
            PC_REL:  pc_next = pc_reg + {operand[61:0], 2'b00};
            default: pc_next = pc_reg;
        endcase
    end

    // PC register, frozen while the sequencer is stalled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_reg <= RESET_PC;
        end else if (enable) begin
            pc_reg <= pc_next;
        end
    end

endmodule

// File: rtl/controlword_sequencer.sv
// Sequential back end of the control unit: unpacks the selected control
// word, owns PC, control state and status registers, and freezes itself
// while a RAM access is outstanding, faulting if the wait runs too long.
module controlword_sequencer
    import controlword_pkg::*;
#(
    parameter int          MEM_TIMEOUT = 15,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [CW_WIDTH-1:0]     controlword,
    input  logic [63:0]             constant,
    input  logic [STATUS_WIDTH-1:0] alu_status,
    input  logic [63:0]             reg_a_data,
    input  logic                    mem_ready,
    output logic [STATE_WIDTH-1:0]  state,
    output logic [STATUS_WIDTH-1:0] status,
    output logic [STATUS_WIDTH-1:0] status_to_decoder,
    output logic [63:0]             pc,
    output logic [63:0]             pc_databus,
    output logic                    pc_databus_enable,
    output logic                    register_file_write_gated,
    output logic                    stall,
    output logic                    fault
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    // Unpacked fields used by the sequencer.
    logic                   rf_write;
    logic                   ram_db_en;
    logic                   ram_write;
    logic                   pc_in_sel;
    logic                   status_load;
    logic [STATE_WIDTH-1:0] next_state;
    pc_func_t               pc_func;
    logic                   mem_busy;
    logic [63:0]            operand;

    // Datapath-only fields; reduced here purely so they are referenced.
    logic unused_fields;

    logic [STATE_WIDTH-1:0]  state_reg,  state_next;
    logic [STATUS_WIDTH-1:0] status_reg, status_next;
    logic [CNT_W-1:0]        wait_cnt_reg, wait_cnt_next;
    logic                    fault_reg,  fault_next;
    logic                    wait_inc;

    assign rf_write    = controlword[CW_RF_WRITE];
    assign ram_db_en   = controlword[CW_RAM_DB_EN];
    assign ram_write   = controlword[CW_RAM_WRITE];
    assign pc_in_sel   = controlword[CW_PC_IN_SEL];
    assign status_load = controlword[CW_STATUS_LOAD];
    assign next_state  = controlword[CW_NEXT_STATE_HI:CW_NEXT_STATE_LO];
    assign pc_func     = pc_func_t'(controlword[CW_PC_FUNC_HI:CW_PC_FUNC_LO]);
    assign unused_fields = ^controlword[CW_WIDTH-1:CW_RF_WRITE+1];

    assign mem_busy = ram_db_en | ram_write;
    assign operand  = pc_in_sel ? constant : reg_a_data;

    // A completed access (mem_ready) always wins over the timeout.
    assign stall    = (mem_busy & ~mem_ready) | fault_reg;
    assign wait_inc = mem_busy & ~mem_ready & ~fault_reg;

    assign state                     = state_reg;
    assign status                    = status_reg;
    assign fault                     = fault_reg;
    assign pc_databus_enable         = controlword[CW_PC_DB_EN];
    assign register_file_write_gated = rf_write & ~stall;
    // Z bypasses the register so CBZ/CBNZ see the current ALU pass.
    assign status_to_decoder = {status_reg[STATUS_WIDTH-1:1], alu_status[STATUS_Z]};

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock   (clock),
        .reset   (reset),
        .enable  (~stall),
        .func    (pc_func),
        .operand (operand),
        .pc      (pc),
        .pc_seq  (pc_databus)
    );

    // Next values for control state, status, wait counter and fault flag.
    always_comb begin
        state_next    = state_reg;
        status_next   = status_reg;
        wait_cnt_next = '0;
        fault_next    = fault_reg;
        if (!stall) begin
            state_next = next_state;
            if (status_load) begin
                status_next = alu_status;
            end
        end
        if (wait_inc) begin
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
            if (wait_cnt_reg == CNT_W'(MEM_TIMEOUT - 1)) begin
                fault_next = 1'b1;
            end
        end
    end

    // Architectural control registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= '0;
            status_reg   <= '0;
            wait_cnt_reg <= '0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            status_reg   <= status_next;
            wait_cnt_reg <= wait_cnt_next;
            fault_reg    <= fault_next;
        end
    end

endmodule
